// File: rtl/exe_stage_mc_if.sv
// Execute-stage bus: ID/EXE operands and controls in, EXE/MEM bank and status out.
// Latency: none, wires only.
// Backpressure: in_ready from the stage; freeze and flush from the hazard unit.
interface exe_stage_mc_if #(
  parameter int WIDTH  = 32,
  parameter int DEST_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              freeze;
  logic              flush;
  logic              S;
  logic              WB_EN;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [3:0]        EXE_CMD;
  logic              immediate;
  logic [11:0]       shift_operand_in;
  logic [23:0]       signed_imm_24;
  logic [WIDTH-1:0]  PC_in;
  logic [WIDTH-1:0]  Val1;
  logic [WIDTH-1:0]  Val_Rm;
  logic [DEST_W-1:0] dest_in;
  logic [1:0]        src1_sel;
  logic [1:0]        src2_sel;
  logic [WIDTH-1:0]  fwd_mem;
  logic [WIDTH-1:0]  fwd_wb;
  logic [WIDTH-1:0]  branch_address;
  logic [3:0]        status_bits;
  logic              out_valid;
  logic [WIDTH-1:0]  ALU_Res;
  logic [WIDTH-1:0]  store_data;
  logic [DEST_W-1:0] dest_out;
  logic              WB_EN_out;
  logic              MEM_R_EN_out;
  logic              MEM_W_EN_out;

  modport master (
    output in_valid, freeze, flush, S, WB_EN, MEM_R_EN, MEM_W_EN, EXE_CMD, immediate,
           shift_operand_in, signed_imm_24, PC_in, Val1, Val_Rm, dest_in,
           src1_sel, src2_sel, fwd_mem, fwd_wb,
    input  in_ready, branch_address, status_bits, out_valid, ALU_Res, store_data,
           dest_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out
  );

  modport slave (
    input  in_valid, freeze, flush, S, WB_EN, MEM_R_EN, MEM_W_EN, EXE_CMD, immediate,
           shift_operand_in, signed_imm_24, PC_in, Val1, Val_Rm, dest_in,
           src1_sel, src2_sel, fwd_mem, fwd_wb,
    output in_ready, branch_address, status_bits, out_valid, ALU_Res, store_data,
           dest_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out
  );
endinterface

// File: rtl/exe_stage_mc.sv
// ARM-subset execute stage: forwarding, shifter, ALU, NZCV, iterative multiplier, EXE/MEM bank.
// Latency: 1 edge for ALU ops, WIDTH/MUL_BITS edges after accept for MUL.
// Backpressure: in_ready low while multiplying or frozen; freeze holds all state, flush squashes.
module exe_stage_mc #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 2,
  parameter int DEST_W   = 4
) (
  input logic           clk,
  input logic           rst,
  exe_stage_mc_if.slave bus
);
  localparam int STEPS = WIDTH / MUL_BITS;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  localparam logic [3:0] C_MOV = 4'b0001, C_MVN = 4'b1001, C_ADD = 4'b0010, C_ADC = 4'b0011;
  localparam logic [3:0] C_SUB = 4'b0100, C_SBC = 4'b0101, C_AND = 4'b0110, C_ORR = 4'b0111;
  localparam logic [3:0] C_EOR = 4'b1000, C_MUL = 4'b1010;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic [WIDTH-1:0]  op1, rm, val2, bval, alu_res;
  logic [WIDTH:0]    sum;
  logic              cin, is_arith, known, ovf;
  logic [3:0]        status, flags_next;
  logic [31:0]       sh_amt, rot_amt;
  logic [WIDTH-1:0]  mcand, mplier, acc, pp, acc_next;
  logic [CW-1:0]     cnt;
  logic              out_valid_q, wb_q, mr_q, mw_q;
  logic [WIDTH-1:0]  res_q, store_q;
  logic [DEST_W-1:0] dest_q;
  logic              mul_s, mul_wb, mul_mr, mul_mw;
  logic [DEST_W-1:0] mul_dest;
  logic [WIDTH-1:0]  mul_store;

  function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x, input logic [31:0] amt);
    logic [2*WIDTH-1:0] d;
    d = {x, x} >> amt;
    return d[WIDTH-1:0];
  endfunction

  assign bus.in_ready       = (state == IDLE) && !bus.freeze;
  assign bus.branch_address = bus.PC_in + WIDTH'($signed({bus.signed_imm_24, 2'b00}));
  assign bus.status_bits    = status;
  assign bus.out_valid      = out_valid_q;
  assign bus.ALU_Res        = res_q;
  assign bus.store_data     = store_q;
  assign bus.dest_out       = dest_q;
  assign bus.WB_EN_out      = wb_q;
  assign bus.MEM_R_EN_out   = mr_q;
  assign bus.MEM_W_EN_out   = mw_q;

  // Forwarding muxes and operand-2 generation (memory offset, rotated imm8, or shifted rm).
  always_comb begin
    op1 = bus.Val1;
    if (bus.src1_sel == 2'b01) op1 = bus.fwd_mem;
    else if (bus.src1_sel == 2'b10) op1 = bus.fwd_wb;
    rm = bus.Val_Rm;
    if (bus.src2_sel == 2'b01) rm = bus.fwd_mem;
    else if (bus.src2_sel == 2'b10) rm = bus.fwd_wb;
    sh_amt  = 32'(bus.shift_operand_in[11:7]) & 32'(WIDTH - 1);
    rot_amt = 32'({bus.shift_operand_in[11:8], 1'b0}) & 32'(WIDTH - 1);
    if (bus.MEM_R_EN || bus.MEM_W_EN) begin
      val2 = WIDTH'(bus.shift_operand_in);
    end else if (bus.immediate) begin
      val2 = ror(WIDTH'(bus.shift_operand_in[7:0]), rot_amt);
    end else begin
      case (bus.shift_operand_in[6:5])
        2'b00:   val2 = rm << sh_amt;
        2'b01:   val2 = rm >> sh_amt;
        2'b10:   val2 = $unsigned($signed(rm) >>> sh_amt);
        default: val2 = ror(rm, sh_amt);
      endcase
    end
  end

  // ALU with WIDTH+1 carry chain; subtraction is a + ~b + cin so carry means no borrow.
  always_comb begin
    is_arith = (bus.EXE_CMD == C_ADD) || (bus.EXE_CMD == C_ADC) ||
               (bus.EXE_CMD == C_SUB) || (bus.EXE_CMD == C_SBC);
    bval = ((bus.EXE_CMD == C_SUB) || (bus.EXE_CMD == C_SBC)) ? ~val2 : val2;
    cin  = 1'b0;
    if (bus.EXE_CMD == C_SUB) cin = 1'b1;
    else if ((bus.EXE_CMD == C_ADC) || (bus.EXE_CMD == C_SBC)) cin = status[1];
    sum   = {1'b0, op1} + {1'b0, bval} + {{WIDTH{1'b0}}, cin};
    known = 1'b1;
    case (bus.EXE_CMD)
      C_MOV:                      alu_res = val2;
      C_MVN:                      alu_res = ~val2;
      C_ADD, C_ADC, C_SUB, C_SBC: alu_res = sum[WIDTH-1:0];
      C_AND:                      alu_res = op1 & val2;
      C_ORR:                      alu_res = op1 | val2;
      C_EOR:                      alu_res = op1 ^ val2;
      default: begin
        alu_res = '0;
        known   = 1'b0;
      end
    endcase
    ovf = (op1[WIDTH-1] == bval[WIDTH-1]) && (alu_res[WIDTH-1] != op1[WIDTH-1]);
    flags_next = {alu_res[WIDTH-1], alu_res == '0,
                  is_arith ? sum[WIDTH] : status[1],
                  is_arith ? ovf : status[0]};
  end

  // Partial product of the next MUL_BITS multiplier bits against the pre-shifted multiplicand.
  always_comb begin
    pp = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mplier[i]) pp = pp + (mcand << i);
    end
    acc_next = acc + pp;
  end

  // Control FSM, multiplier state, NZCV and the EXE/MEM output bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      store_q     <= '0;
      dest_q      <= '0;
      wb_q        <= 1'b0;
      mr_q        <= 1'b0;
      mw_q        <= 1'b0;
      status      <= 4'b0000;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      mul_s       <= 1'b0;
      mul_wb      <= 1'b0;
      mul_mr      <= 1'b0;
      mul_mw      <= 1'b0;
      mul_dest    <= '0;
      mul_store   <= '0;
    end else if (bus.flush) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
    end else if (!bus.freeze) begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.EXE_CMD == C_MUL) begin
            mcand       <= op1;
            mplier      <= val2;
            acc         <= '0;
            cnt         <= '0;
            mul_s       <= bus.S;
            mul_wb      <= bus.WB_EN;
            mul_mr      <= bus.MEM_R_EN;
            mul_mw      <= bus.MEM_W_EN;
            mul_dest    <= bus.dest_in;
            mul_store   <= rm;
            out_valid_q <= 1'b0;
            state       <= BUSY;
          end else if (bus.in_valid) begin
            res_q       <= alu_res;
            store_q     <= rm;
            dest_q      <= bus.dest_in;
            wb_q        <= bus.WB_EN;
            mr_q        <= bus.MEM_R_EN;
            mw_q        <= bus.MEM_W_EN;
            out_valid_q <= 1'b1;
            if (bus.S && known) status <= flags_next;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          acc    <= acc_next;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            res_q       <= acc_next;
            store_q     <= mul_store;
            dest_q      <= mul_dest;
            wb_q        <= mul_wb;
            mr_q        <= mul_mr;
            mw_q        <= mul_mw;
            out_valid_q <= 1'b1;
            if (mul_s) status <= {acc_next[WIDTH-1], acc_next == '0, status[1:0]};
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_exe_stage_mc.sv
// Self-checking bench for exe_stage_mc: scoreboard of expected EXE/MEM results with arrival edges.
// Latency: expectations carry the edge number on which each result must appear.
// Backpressure: exercises MUL stall, freeze, flush and asynchronous reset mid-multiply.
module tb_exe_stage_mc;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_stage_mc_if #(.WIDTH(W), .DEST_W(4)) bus();
  exe_stage_mc #(.WIDTH(W), .MUL_BITS(2), .DEST_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic [3:0]  nzcv;
    logic [31:0] store;
    logic [3:0]  dest;
    logic        mr;
    int          at;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         edge_n = 0;
  logic       frz_at_edge = 1'b0;
  logic [3:0] dest_ctr = 4'd0;
  int         lowcnt;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Edge counter and record of whether each edge was frozen.
  always @(posedge clk) begin
    edge_n++;
    frz_at_edge = bus.freeze;
  end

  // Output monitor: every fresh out_valid pops one expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && !frz_at_edge) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out", bus.out_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val("alu_res", bus.ALU_Res, mon_e.res);
        check_val("nzcv", bus.status_bits, mon_e.nzcv);
        check_val("store_data", bus.store_data, mon_e.store);
        check_val("dest_out", bus.dest_out, mon_e.dest);
        check_val("mem_r_out", bus.MEM_R_EN_out, mon_e.mr);
        check_val("wb_out", bus.WB_EN_out, 1);
        check_val("arrival_edge", edge_n, mon_e.at);
      end
    end
  end

  task automatic issue(input logic [3:0] cmd, input logic mem, input logic imm, input logic [11:0] sh,
                       input logic s, input logic [31:0] v1, input logic [31:0] rm,
                       input logic [31:0] eres, input logic [3:0] enz, input logic [31:0] estore,
                       input int lat, input bit expect_out);
    exp_t e;
    @(negedge clk); #1;
    bus.EXE_CMD = cmd;
    bus.MEM_R_EN = mem;
    bus.immediate = imm;
    bus.shift_operand_in = sh;
    bus.S = s;
    bus.Val1 = v1;
    bus.Val_Rm = rm;
    bus.dest_in = dest_ctr;
    bus.in_valid = 1'b1;
    if (expect_out) begin
      e.res = eres; e.nzcv = enz; e.store = estore; e.dest = dest_ctr; e.mr = mem; e.at = edge_n + lat;
      sb.push_back(e);
    end
    dest_ctr++;
    @(negedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk); #1;
    end
    check_val("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.freeze = 0; bus.flush = 0; bus.S = 0;
    bus.WB_EN = 1; bus.MEM_R_EN = 0; bus.MEM_W_EN = 0; bus.EXE_CMD = 0; bus.immediate = 0;
    bus.shift_operand_in = 0; bus.signed_imm_24 = 24'hFFFFFE; bus.PC_in = 32'h100;
    bus.Val1 = 0; bus.Val_Rm = 0; bus.dest_in = 0; bus.src1_sel = 0; bus.src2_sel = 0;
    bus.fwd_mem = 0; bus.fwd_wb = 0;

    repeat (2) @(negedge clk);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_alu_res", bus.ALU_Res, 0);
    check_val("rst_status", bus.status_bits, 0);
    check_val("rst_in_ready", bus.in_ready, 1);
    check_val("rst_dest", bus.dest_out, 0);
    rst = 1'b0;
    #1;
    check_val("branch_address", bus.branch_address, 32'h0000_00F8);

    issue(4'b0010, 0, 1, 12'h001, 1, 32'hFFFF_FFFF, 0, 32'h0, 4'b0110, 0, 1, 1); drain();
    issue(4'b0001, 0, 1, 12'h4FF, 0, 0, 0, 32'hFF00_0000, 4'b0110, 0, 1, 1); drain();
    bus.src2_sel = 2'b01; bus.fwd_mem = 32'd5;
    issue(4'b0100, 0, 0, 12'h000, 1, 32'd3, 32'h77, 32'hFFFF_FFFE, 4'b1000, 32'd5, 1, 1); drain();
    bus.src2_sel = 2'b00; bus.src1_sel = 2'b10; bus.fwd_wb = 32'h20;
    issue(4'b0010, 0, 1, 12'h001, 0, 32'h999, 32'h1, 32'h21, 4'b1000, 32'h1, 1, 1); drain();
    bus.src1_sel = 2'b00;
    issue(4'b0111, 0, 0, 12'h220, 1, 32'h10, 32'h8000_0000, 32'h0800_0010, 4'b0000, 32'h8000_0000, 1, 1); drain();
    issue(4'b0001, 0, 0, 12'h240, 1, 0, 32'h8000_0000, 32'hF800_0000, 4'b1000, 32'h8000_0000, 1, 1); drain();
    issue(4'b1001, 0, 0, 12'h260, 0, 0, 32'hF, 32'h0FFF_FFFF, 4'b1000, 32'hF, 1, 1); drain();
    issue(4'b0010, 0, 1, 12'h002, 1, 32'hFFFF_FFFF, 0, 32'h1, 4'b0010, 0, 1, 1); drain();
    issue(4'b0011, 0, 1, 12'h001, 1, 32'h1, 0, 32'h3, 4'b0000, 0, 1, 1); drain();
    issue(4'b0101, 0, 1, 12'h001, 1, 32'h5, 0, 32'h3, 4'b0010, 0, 1, 1); drain();
    issue(4'b0010, 0, 1, 12'h001, 1, 32'h7FFF_FFFF, 0, 32'h8000_0000, 4'b1001, 0, 1, 1); drain();
    issue(4'b0010, 1, 1, 12'hABC, 0, 32'h1000, 0, 32'h1ABC, 4'b1001, 0, 1, 1); drain();
    issue(4'b1111, 0, 1, 12'h001, 1, 32'h5, 0, 32'h0, 4'b1001, 0, 1, 1); drain();
    issue(4'b0110, 0, 1, 12'h0FF, 1, 32'hF0F0, 0, 32'hF0, 4'b0001, 0, 1, 1); drain();
    issue(4'b1000, 0, 1, 12'h0FF, 1, 32'hFF, 0, 32'h0, 4'b0101, 0, 1, 1); drain();

    // MUL 7*6: stall for 16 cycles, result 16 edges after the accept edge.
    issue(4'b1010, 0, 0, 12'h000, 1, 32'd7, 32'd6, 32'd42, 4'b0001, 32'd6, 17, 1);
    lowcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.in_ready) break;
      lowcnt++;
      @(negedge clk); #1;
    end
    check_val("mul_stall_cycles", lowcnt, 16);
    check_val("mul_ready_after", bus.in_ready, 1);
    drain();

    // MUL flushed in its 5th busy cycle; a same-cycle instruction is dropped too.
    issue(4'b1010, 0, 0, 12'h000, 1, 32'd3, 32'd5, 0, 0, 0, 17, 0);
    repeat (4) @(negedge clk);
    #1;
    bus.flush = 1; bus.in_valid = 1; bus.EXE_CMD = 4'b0010; bus.immediate = 1;
    bus.shift_operand_in = 12'h001; bus.Val1 = 32'hFFFF_FFFF; bus.S = 1;
    @(negedge clk); #1;
    bus.flush = 0; bus.in_valid = 0;
    check_val("flush_ready", bus.in_ready, 1);
    check_val("flush_out_valid", bus.out_valid, 0);
    check_val("flush_status", bus.status_bits, 4'b0001);
    repeat (20) @(negedge clk);
    #1;
    bus.flush = 1; bus.in_valid = 1;
    @(negedge clk); #1;
    bus.flush = 0; bus.in_valid = 0;
    check_val("flush_idle_out_valid", bus.out_valid, 0);
    check_val("flush_idle_status", bus.status_bits, 4'b0001);

    // MUL 9*9 frozen for 3 edges mid-multiply: result 3 edges late.
    issue(4'b1010, 0, 0, 12'h000, 0, 32'd9, 32'd9, 32'd81, 4'b0001, 32'd9, 20, 1);
    repeat (4) @(negedge clk);
    #1;
    bus.freeze = 1;
    #1;
    check_val("freeze_ready", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    #1;
    bus.freeze = 0;
    drain();

    // Asynchronous reset in the middle of a multiply.
    issue(4'b1010, 0, 0, 12'h000, 1, 32'd2, 32'd3, 0, 0, 0, 17, 0);
    repeat (5) @(negedge clk);
    #1;
    rst = 1;
    #1;
    check_val("arst_alu_res", bus.ALU_Res, 0);
    check_val("arst_status", bus.status_bits, 0);
    check_val("arst_store", bus.store_data, 0);
    check_val("arst_dest", bus.dest_out, 0);
    check_val("arst_wb", bus.WB_EN_out, 0);
    check_val("arst_out_valid", bus.out_valid, 0);
    @(negedge clk); #1;
    rst = 0;
    #1;
    check_val("arst_ready", bus.in_ready, 1);
    repeat (20) @(negedge clk);
    #1;
    check_val("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
